// File: rtl/drone_pkg.sv
// rtl/drone_pkg.sv - shared RPM types and ramp FSM states for the motor path
package drone_pkg;

  localparam int RPM_W = 7;

  typedef logic [RPM_W-1:0] rpm_t;

  typedef enum logic [1:0] {
    DISARMED,
    ARMING,
    RUN
  } ramp_state_e;

endpackage

// File: rtl/rpm_slew.sv
// rtl/rpm_slew.sv - combinational clamp-step of one RPM value toward a target
module rpm_slew
  import drone_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [RPM_W-1:0] cur,
  input  logic [RPM_W-1:0] target,
  output logic [RPM_W-1:0] next_rpm
);

  localparam logic signed [RPM_W:0] STEP_S = (RPM_W+1)'(STEP);

  logic signed [RPM_W:0] diff;

  // One extra bit keeps the signed difference exact, so the step never wraps past 0 or full scale.
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, cur});
    if (diff > STEP_S) begin
      next_rpm = cur + RPM_W'(STEP);
    end else if (diff < -STEP_S) begin
      next_rpm = cur - RPM_W'(STEP);
    end else begin
      next_rpm = target;
    end
  end

endmodule

// File: rtl/motor_rpm_ramp.sv
// rtl/motor_rpm_ramp.sv - armed, slew-limited RPM command feeding the PWM stage
module motor_rpm_ramp
  import drone_pkg::*;
#(
  parameter int STEP     = 4,
  parameter int PERIOD   = 2**RPM_W,
  parameter int ARM_HOLD = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             arm,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [RPM_W-1:0] cmd_rpm,
  output logic [RPM_W-1:0] mot_rpm,
  output logic             tick,
  output logic             armed,
  output logic             at_target
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int HOLD_W = $clog2(ARM_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ARM_HOLD - 1);

  ramp_state_e       state;
  ramp_state_e       next_state;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;
  rpm_t              target;
  rpm_t              slew_next;
  logic              accept;

  rpm_slew #(
    .STEP(STEP)
  ) u_slew (
    .cur     (mot_rpm),
    .target  (target),
    .next_rpm(slew_next)
  );

  assign accept    = cmd_valid && cmd_ready;
  assign at_target = armed && (mot_rpm == target);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DISARMED;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    armed      = 1'b0;
    case (state)
      DISARMED: begin
        if (arm) next_state = ARMING;
      end
      ARMING: begin
        cmd_ready = 1'b1;
        if (!arm) begin
          next_state = DISARMED;
        end else if (tick && (hold == HOLD_LAST)) begin
          next_state = RUN;
        end
      end
      RUN: begin
        cmd_ready = 1'b1;
        armed     = 1'b1;
        if (!arm) next_state = DISARMED;
      end
      default: next_state = DISARMED;
    endcase
  end

  // Free-running period counter; tick is its registered wrap so mot_rpm moves on the edge ending the tick cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == CNT_LAST);
    end
  end

  // Disarm drops the motor immediately, ignoring period alignment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mot_rpm <= '0;
      target  <= '0;
      hold    <= '0;
    end else if (!arm) begin
      mot_rpm <= '0;
      target  <= '0;
      hold    <= '0;
    end else begin
      case (state)
        DISARMED: begin
          mot_rpm <= '0;
          target  <= '0;
          hold    <= '0;
        end
        ARMING: begin
          mot_rpm <= '0;
          if (accept) target <= cmd_rpm;
          if (tick) hold <= hold + HOLD_W'(1);
        end
        RUN: begin
          if (accept) target <= cmd_rpm;
          if (tick) mot_rpm <= slew_next;
        end
        default: begin
          mot_rpm <= '0;
          target  <= '0;
          hold    <= '0;
        end
      endcase
    end
  end

endmodule
